amo_ctrl: RTL and testbench

- Sequencer for RV32A atomic memory operations (AMOs).
- Sits between the execute stage and the data-memory port, directly upstream of the `atomic` ALU.
- Performs the read-modify-write sequence: reads the old word, drives the ALU with the old word and rs2, writes the ALU result back, and returns the old word to rd.
- Also handles LR.W/SC.W with a single-entry reservation.

---
 rtl/amo_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_amo_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_ctrl.sv
// -----------------------------------------------------------------------------
// amo_ctrl -- RV32A atomic memory operation sequencer.
//
// Runs the read-modify-write sequence for AMO*.W: it reads the old word,
// presents {old, rs2, op} to the external combinational `atomic` ALU, writes
// the result back and returns the old word as rd. With AMO_LRSC_EN defined it
// also executes LR.W/SC.W against a single-entry reservation that is killed by
// snooped stores. Without AMO_LRSC_EN, LR/SC are rejected as illegal ops.
//
// Optional feature macro: AMO_LRSC_EN (LR/SC paths, reservation, snoop).
//
// Ports
//   clk, reset                       clock, async active-high reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_op, req_addr, req_wdata      funct5, byte address, rs2
//   alu_a, alu_b, alu_op             operands/op to the atomic ALU
//   alu_result                       combinational ALU result
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ready, mem_rdata  data-memory port (held until mem_ready)
//   snoop_we, snoop_addr             external store observed for the reservation
//   resp_valid, resp_data, resp_err  one-cycle completion pulse with rd / error
// -----------------------------------------------------------------------------
module amo_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [4:0]        alu_op,
  input  logic [31:0]       alu_result,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CALC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [4:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_old;
  logic [31:0]         r_mem_wdata;
  logic                r_req_ready;
  logic                r_mem_req;
  logic                r_mem_we;
  logic                r_resp_valid;
  logic [31:0]         r_resp_data;
  logic                r_resp_err;
  logic                w_accept;
  logic                w_legal;
  logic                w_bad_req;
  logic                w_sc_ok;
  logic                w_done_err;
  logic [31:0]         w_done_data;

  // Ops that go through the atomic ALU.
  function automatic logic is_alu_op(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SWAP, OP_XOR, OP_OR, OP_AND,
      OP_MIN, OP_MAX, OP_MINU, OP_MAXU: is_alu_op = 1'b1;
      default:                          is_alu_op = 1'b0;
    endcase
  endfunction

  assign w_accept  = req_valid & r_req_ready;
  assign w_bad_req = (req_addr[1:0] != 2'b00) | ~w_legal;

`ifdef AMO_LRSC_EN
  logic                r_resv_valid;
  logic [ADDR_W-3:0]   r_resv_addr;
  logic                w_resv_match;
  logic                w_lr_set;
  logic                w_snoop_lr;
  logic                w_resv_clr;

  assign w_legal      = is_alu_op(req_op) | (req_op == OP_LR) | (req_op == OP_SC);
  assign w_resv_match = r_resv_valid & (req_addr[ADDR_W-1:2] == r_resv_addr);
  assign w_lr_set     = (r_state == S_READ) & mem_ready & (r_op == OP_LR);
  // A snoop hitting the word an LR is reserving right now must still win.
  assign w_snoop_lr   = snoop_we & (snoop_addr[ADDR_W-1:2] == r_addr[ADDR_W-1:2]);
  assign w_resv_clr   = (w_accept & (req_op == OP_SC))
                      | (snoop_we & (snoop_addr[ADDR_W-1:2] == r_resv_addr))
                      | ((r_state == S_WRITE) & mem_ready & (r_op != OP_SC)
                         & (r_addr[ADDR_W-1:2] == r_resv_addr));

  // Single-entry LR reservation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resv_valid <= 1'b0;
      r_resv_addr  <= {(ADDR_W-2){1'b0}};
    end else if (w_lr_set) begin
      r_resv_valid <= ~w_snoop_lr;
      r_resv_addr  <= r_addr[ADDR_W-1:2];
    end else if (w_resv_clr) begin
      r_resv_valid <= 1'b0;
    end
  end
`else
  logic w_unused_snoop;
  assign w_unused_snoop = ^{snoop_we, snoop_addr};
  assign w_legal        = is_alu_op(req_op);
`endif

  // Next-state decode plus the rd/err value to present when entering DONE.
  always_comb begin
    w_next_state = r_state;
    w_done_data  = 32'h0000_0000;
    w_done_err   = 1'b0;
    w_sc_ok      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_bad_req) begin
            w_next_state = S_DONE;
            w_done_err   = 1'b1;
          end
`ifdef AMO_LRSC_EN
          else if (req_op == OP_SC) begin
            if (w_resv_match) begin
              w_next_state = S_WRITE;
              w_sc_ok      = 1'b1;
            end else begin
              w_next_state = S_DONE;
              w_done_data  = 32'h0000_0001;
            end
          end
`endif
          else begin
            w_next_state = S_READ;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_READ: begin
        if (mem_ready) begin
`ifdef AMO_LRSC_EN
          if (r_op == OP_LR) begin
            w_next_state = S_DONE;
            w_done_data  = mem_rdata;
          end else begin
            w_next_state = S_CALC;
          end
`else
          w_next_state = S_CALC;
`endif
        end else begin
          w_next_state = S_READ;
        end
      end
      S_CALC: begin
        w_next_state = S_WRITE;
      end
      S_WRITE: begin
        if (mem_ready) begin
          w_next_state = S_DONE;
          w_done_data  = (r_op == OP_SC) ? 32'h0000_0000 : r_old;
        end else begin
          w_next_state = S_WRITE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, request latches, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_op         <= 5'b00000;
      r_addr       <= {ADDR_W{1'b0}};
      r_wdata      <= 32'h0000_0000;
      r_old        <= 32'h0000_0000;
      r_mem_wdata  <= 32'h0000_0000;
      r_req_ready  <= 1'b1;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'h0000_0000;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_req_ready  <= (w_next_state == S_IDLE);
      r_mem_req    <= (w_next_state == S_READ) | (w_next_state == S_WRITE);
      r_mem_we     <= (w_next_state == S_WRITE);
      r_resp_valid <= (w_next_state == S_DONE);
      r_resp_data  <= (w_next_state == S_DONE) ? w_done_data : 32'h0000_0000;
      r_resp_err   <= (w_next_state == S_DONE) & w_done_err;
      if (w_accept) begin
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if ((r_state == S_READ) & mem_ready) begin
        r_old <= mem_rdata;
      end
      // SC data is captured at accept; AMO data comes from the ALU in CALC.
      if (w_sc_ok) begin
        r_mem_wdata <= req_wdata;
      end else if (r_state == S_CALC) begin
        r_mem_wdata <= alu_result;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign alu_a      = r_old;
  assign alu_b      = r_wdata;
  assign alu_op     = r_op;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = r_mem_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_amo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_amo_ctrl -- directed self-checking bench for amo_ctrl.
// Provides a behavioural atomic ALU and a data memory with programmable wait
// states. Expected values are hand-computed; LR/SC expectations follow whether
// AMO_LRSC_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_amo_ctrl;

`ifdef AMO_LRSC_EN
  localparam bit LRSC = 1'b1;
`else
  localparam bit LRSC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_result;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        snoop_we;
  logic [31:0] snoop_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  always #5 clk = ~clk;

  amo_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .snoop_we(snoop_we), .snoop_addr(snoop_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  // Behavioural RV32A atomic ALU.
  always_comb begin
    case (alu_op)
      5'b00000: alu_result = alu_a + alu_b;
      5'b00001: alu_result = alu_b;
      5'b00100: alu_result = alu_a ^ alu_b;
      5'b01000: alu_result = alu_a | alu_b;
      5'b01100: alu_result = alu_a & alu_b;
      5'b10000: alu_result = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
      5'b10100: alu_result = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
      5'b11000: alu_result = (alu_a < alu_b) ? alu_a : alu_b;
      5'b11100: alu_result = (alu_a > alu_b) ? alu_a : alu_b;
      default:  alu_result = 32'h0;
    endcase
  end

  // Memory model: all array writes happen in this one process.
  logic [31:0] mem [0:1023];
  logic [9:0]  poke_idx = 10'd0;
  logic [31:0] poke_val = 32'h0;
  logic        poke_go  = 1'b0;
  logic        stall_we = 1'b0;
  int          wait_cfg = 0;
  int          w_cnt    = 0;
  int          req_cycles = 0;
  int          n_writes = 0;
  logic [31:0] last_wr_addr = 32'h0;

  always @(negedge clk) begin
    if (poke_go) mem[poke_idx] = poke_val;
    if (mem_req) begin
      req_cycles = req_cycles + 1;
      if (mem_we && stall_we) begin
        mem_ready = 1'b0;
      end else if (w_cnt == wait_cfg) begin
        mem_ready = 1'b1;
        w_cnt = 0;
        if (mem_we) begin
          mem[mem_addr[11:2]] = mem_wdata;
          n_writes = n_writes + 1;
          last_wr_addr = mem_addr;
        end else begin
          mem_rdata = mem[mem_addr[11:2]];
        end
      end else begin
        mem_ready = 1'b0;
        w_cnt = w_cnt + 1;
      end
    end else begin
      mem_ready = 1'b0;
      w_cnt = 0;
    end
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] val);
    poke_idx = addr[11:2];
    poke_val = val;
    poke_go  = 1'b1;
    @(negedge clk);
    #1 poke_go = 1'b0;
  endtask

  function automatic logic [31:0] peek(input logic [31:0] addr);
    return mem[addr[11:2]];
  endfunction

  // Issue one request; lat counts cycles from accept to resp_valid (0 = timeout).
  task automatic run_req(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] data, output logic err);
    lat  = 0;
    data = 32'hDEAD_BEEF;
    err  = 1'b0;
    @(negedge clk);
    check_eq("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat  = i;
        data = resp_data;
        err  = resp_err;
        break;
      end
    end
  endtask

  int          lat;
  logic [31:0] d;
  logic        e;
  int          rc0;
  int          wr0;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 5'd0; req_addr = 32'h0; req_wdata = 32'h0;
    snoop_we = 1'b0; snoop_addr = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_data", resp_data, 32'h0);
    check_eq("rst_resp_err", 32'(resp_err), 32'd0);
    check_eq("rst_alu_a", alu_a, 32'h0);
    check_eq("rst_alu_b", alu_b, 32'h0);
    check_eq("rst_alu_op", 32'(alu_op), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;

    // AMOADD.W, zero wait
    poke(32'h100, 32'd5);
    run_req(5'b00000, 32'h100, 32'd3, lat, d, e);
    check_eq("add_lat", 32'(lat), 32'd4);
    check_eq("add_data", d, 32'd5);
    check_eq("add_err", 32'(e), 32'd0);
    check_eq("add_mem", peek(32'h100), 32'd8);
    check_eq("add_wr_addr", last_wr_addr, 32'h100);

    // AMOMAX.W with two wait cycles per access
    poke(32'h104, 32'hFFFF_FFFF);
    wait_cfg = 2;
    wr0 = n_writes;
    run_req(5'b10100, 32'h104, 32'd1, lat, d, e);
    wait_cfg = 0;
    check_eq("max_lat", 32'(lat), 32'd8);
    check_eq("max_data", d, 32'hFFFF_FFFF);
    check_eq("max_mem", peek(32'h104), 32'd1);
    check_eq("max_nwr", 32'(n_writes - wr0), 32'd1);

    // AMOXOR.W
    poke(32'h108, 32'h0000_F0F0);
    run_req(5'b00100, 32'h108, 32'h0000_00FF, lat, d, e);
    check_eq("xor_data", d, 32'h0000_F0F0);
    check_eq("xor_mem", peek(32'h108), 32'h0000_F00F);

    // LR/SC pair, then a second SC
    poke(32'h200, 32'd7);
    rc0 = req_cycles;
    run_req(5'b00010, 32'h200, 32'd0, lat, d, e);
    check_eq("lr_lat", 32'(lat), LRSC ? 32'd2 : 32'd1);
    check_eq("lr_data", d, LRSC ? 32'd7 : 32'd0);
    check_eq("lr_err", 32'(e), LRSC ? 32'd0 : 32'd1);
    check_eq("lr_memcyc", 32'(req_cycles - rc0), LRSC ? 32'd1 : 32'd0);
    run_req(5'b00011, 32'h200, 32'd9, lat, d, e);
    check_eq("sc_lat", 32'(lat), LRSC ? 32'd2 : 32'd1);
    check_eq("sc_data", d, 32'd0);
    check_eq("sc_err", 32'(e), LRSC ? 32'd0 : 32'd1);
    check_eq("sc_mem", peek(32'h200), LRSC ? 32'd9 : 32'd7);
    rc0 = req_cycles;
    run_req(5'b00011, 32'h200, 32'd11, lat, d, e);
    check_eq("sc2_lat", 32'(lat), 32'd1);
    check_eq("sc2_data", d, LRSC ? 32'd1 : 32'd0);
    check_eq("sc2_memcyc", 32'(req_cycles - rc0), 32'd0);

    // Snoop kills the reservation
    poke(32'h300, 32'h33);
    run_req(5'b00010, 32'h300, 32'd0, lat, d, e);
    check_eq("lr3_data", d, LRSC ? 32'h33 : 32'h0);
    @(negedge clk);
    snoop_we = 1'b1; snoop_addr = 32'h302;
    @(negedge clk);
    snoop_we = 1'b0;
    wr0 = n_writes;
    run_req(5'b00011, 32'h300, 32'h44, lat, d, e);
    check_eq("snp_sc_data", d, LRSC ? 32'd1 : 32'd0);
    check_eq("snp_sc_err", 32'(e), LRSC ? 32'd0 : 32'd1);
    check_eq("snp_nwr", 32'(n_writes - wr0), 32'd0);
    check_eq("snp_mem", peek(32'h300), 32'h33);

    // Misaligned AMOSWAP and an undefined funct5
    rc0 = req_cycles;
    run_req(5'b00001, 32'h101, 32'h55, lat, d, e);
    check_eq("mis_lat", 32'(lat), 32'd1);
    check_eq("mis_err", 32'(e), 32'd1);
    check_eq("mis_data", d, 32'd0);
    check_eq("mis_memcyc", 32'(req_cycles - rc0), 32'd0);
    run_req(5'b00101, 32'h10C, 32'h1, lat, d, e);
    check_eq("ill_lat", 32'(lat), 32'd1);
    check_eq("ill_err", 32'(e), 32'd1);

    // Reset in the middle of an AMO write
    poke(32'h400, 32'h4);
    run_req(5'b00010, 32'h400, 32'd0, lat, d, e);
    poke(32'h500, 32'h10);
    stall_we = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 5'b00000; req_addr = 32'h500; req_wdata = 32'h1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) break;
    end
    check_eq("rw_in_write", {30'h0, mem_req, mem_we}, 32'd3);
    #2 reset = 1'b1;
    #1 check_eq("rw_mem_req_async", 32'(mem_req), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stall_we = 1'b0;
    @(negedge clk);
    check_eq("rw_req_ready", 32'(req_ready), 32'd1);
    check_eq("rw_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rw_mem", peek(32'h500), 32'h10);
    run_req(5'b00011, 32'h400, 32'h77, lat, d, e);
    check_eq("rw_sc_data", d, LRSC ? 32'd1 : 32'd0);
    check_eq("rw_sc_err", 32'(e), LRSC ? 32'd0 : 32'd1);
    check_eq("rw_sc_mem", peek(32'h400), 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
